// File: rtl/udp_tx_payload_buf.sv
// udp_tx_payload_buf: stages one UDP payload for my_ip_send, packing bytes big-endian into 32-bit words.
// Latency: send_en pulses the cycle after the wr_last byte is accepted; send_data is valid one cycle after read_data_req.
// Backpressure: wr_ready is low from the last byte until send_end; bytes past MAX_BYTES are dropped and drop_err is set.
//
// Ports:
//   eth_tx_clk, sys_rst_n         clock, async active-low reset
//   wr_en/wr_data/wr_last         byte-wide write side, accepted only while wr_ready=1
//   wr_ready                      registered; high only while collecting a payload
//   send_en                       one-cycle start pulse carrying send_data_num
//   send_data, read_data_req      word read port served while the frame is being sent
//   send_data_num                 committed payload length in bytes, held until send_end
//   send_end                      frame-done pulse; returns the buffer to collecting
//   drop_err                      sticky overflow flag, cleared by the next payload's first byte
module udp_tx_payload_buf #(
  parameter int DEPTH_WORDS = 256,
  parameter int MAX_BYTES   = 1024
) (
  input  logic        eth_tx_clk,
  input  logic        sys_rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        send_en,
  output logic [31:0] send_data,
  output logic [15:0] send_data_num,
  input  logic        read_data_req,
  input  logic        send_end,
  output logic        drop_err
);

  localparam int          ADDR_W  = $clog2(DEPTH_WORDS);
  localparam logic [15:0] MAX_CNT = 16'(MAX_BYTES);
  localparam logic [ADDR_W:0] RD_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t            state;
  logic [15:0]       byte_cnt;
  logic [23:0]       pack;       // lanes 0..2 of the word being assembled
  logic [ADDR_W:0]   rd_ptr;     // one extra bit so it can sit at DEPTH_WORDS
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              overflow;
  logic              keep;
  logic [1:0]        lane;
  logic [31:0]       word_next;
  logic              mem_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       word_cnt;
  logic              rd_avail;
  logic [31:0]       rd_word;

  assign accept   = wr_en && wr_ready;
  assign overflow = (byte_cnt == MAX_CNT);
  assign keep     = accept && !overflow;
  assign lane     = byte_cnt[1:0];
  assign wr_addr  = byte_cnt[ADDR_W+1:2];

  // Lanes after the current one are zero, so a partial final word needs no cleanup.
  always_comb begin
    word_next = 32'h0;
    case (lane)
      2'd0: word_next = {wr_data, 24'h0};
      2'd1: word_next = {pack[23:16], wr_data, 16'h0};
      2'd2: word_next = {pack[23:8], wr_data, 8'h0};
      2'd3: word_next = {pack[23:0], wr_data};
    endcase
  end

  // The last kept byte before the cap also flushes the word, so a payload
  // truncated at MAX_BYTES still has its final word in RAM.
  assign mem_we = keep && ((lane == 2'd3) || wr_last || (byte_cnt == MAX_CNT - 16'd1));

  assign word_cnt = 16'((17'(send_data_num) + 17'd3) >> 2);
  assign rd_avail = (16'(rd_ptr) < word_cnt);
  assign rd_word  = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge eth_tx_clk) begin
    if (mem_we) begin
      mem[wr_addr] <= word_next;
    end
  end

  always_ff @(posedge eth_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= FILL;
      wr_ready      <= 1'b0;
      send_en       <= 1'b0;
      send_data     <= 32'h0;
      send_data_num <= 16'h0;
      drop_err      <= 1'b0;
      byte_cnt      <= 16'h0;
      pack          <= 24'h0;
      rd_ptr        <= '0;
    end else begin
      send_en <= 1'b0;

      // Requests outside SEND or past the payload end read as zero without moving rd_ptr.
      if (read_data_req) begin
        if (state == SEND && rd_avail) begin
          send_data <= rd_word;
          rd_ptr    <= rd_ptr + RD_ONE;
        end else begin
          send_data <= 32'h0;
        end
      end

      case (state)
        FILL: begin
          wr_ready <= 1'b1;
          if (accept) begin
            if (byte_cnt == 16'h0) begin
              drop_err <= 1'b0;
            end
            if (overflow) begin
              drop_err <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 16'd1;
              pack     <= word_next[31:8];
            end
            if (wr_last) begin
              state         <= LAUNCH;
              wr_ready      <= 1'b0;
              send_en       <= 1'b1;
              send_data_num <= overflow ? MAX_CNT : byte_cnt + 16'd1;
            end
          end
        end
        LAUNCH: begin
          state <= SEND;
        end
        SEND: begin
          if (send_end) begin
            state         <= FILL;
            wr_ready      <= 1'b1;
            byte_cnt      <= 16'h0;
            rd_ptr        <= '0;
            send_data_num <= 16'h0;
          end
        end
        default: begin
          state    <= FILL;
          wr_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_payload_buf.sv
module tb_udp_tx_payload_buf;

  localparam int MAXB = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h0;
  logic        wr_last = 1'b0;
  logic        wr_ready;
  logic        send_en;
  logic [31:0] send_data;
  logic [15:0] send_data_num;
  logic        read_data_req = 1'b0;
  logic        send_end = 1'b0;
  logic        drop_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  udp_tx_payload_buf #(.DEPTH_WORDS(256), .MAX_BYTES(MAXB)) dut (
    .eth_tx_clk    (clk),
    .sys_rst_n     (rst_n),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .wr_ready      (wr_ready),
    .send_en       (send_en),
    .send_data     (send_data),
    .send_data_num (send_data_num),
    .read_data_req (read_data_req),
    .send_end      (send_end),
    .drop_err      (drop_err)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Payload is held as a plain byte list; words are derived from it on demand.
  int          m_phase = 0;   // 0 collecting, 1 launching, 2 sending
  logic        m_ready = 1'b0;
  logic        m_en    = 1'b0;
  logic        m_drop  = 1'b0;
  logic [15:0] m_num   = 16'h0;
  logic [31:0] m_data  = 32'h0;
  int          m_rd    = 0;
  int          m_acc   = 0;
  logic [7:0]  pay[$];

  function automatic logic [31:0] mword(input int i);
    logic [31:0] w;
    w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      w = w << 8;
      if (4 * i + j < pay.size()) w[7:0] = pay[4 * i + j];
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_ready = 0; m_en = 0; m_drop = 0;
      m_num = 0; m_data = 0; m_rd = 0; m_acc = 0;
      pay.delete();
    end else begin
      m_en = 0;
      if (read_data_req) begin
        if (m_phase == 2 && m_rd < (int'(m_num) + 3) / 4) begin
          m_data = mword(m_rd);
          m_rd++;
        end else begin
          m_data = 32'h0;
        end
      end
      case (m_phase)
        0: begin
          if (wr_en && m_ready) begin
            if (m_acc == 0) m_drop = 0;
            if (pay.size() < MAXB) pay.push_back(wr_data);
            else m_drop = 1;
            m_acc++;
            if (wr_last) begin
              m_phase = 1; m_en = 1; m_ready = 0;
              m_num = 16'(pay.size());
            end else begin
              m_ready = 1;
            end
          end else begin
            m_ready = 1;
          end
        end
        1: m_phase = 2;
        default: begin
          if (send_end) begin
            m_phase = 0; m_ready = 1; m_num = 0; m_rd = 0; m_acc = 0;
            pay.delete();
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("wr_ready", wr_ready, m_ready);
    chk("send_en", send_en, m_en);
    chk("send_data", send_data, m_data);
    chk("send_data_num", send_data_num, m_num);
    chk("drop_err", drop_err, m_drop);
  end

  // ---------------- stimulus ----------------
  logic [7:0]  txb[$];
  logic [31:0] cap[$];
  logic [15:0] launch_num;
  logic        launch_drop;

  task automatic feed(input bit set_last, input int maxgap);
    int t;
    int g;
    for (int i = 0; i < txb.size(); i++) begin
      g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      repeat (g) begin
        @(negedge clk);
        wr_en = 0;
        wr_data = 8'($urandom);
        wr_last = 1'($urandom);
        read_data_req = ($urandom_range(3, 0) == 0);
      end
      @(negedge clk);
      read_data_req = 0;
      wr_en = 1;
      wr_data = txb[i];
      wr_last = set_last && (i == txb.size() - 1);
      t = 0;
      while (!wr_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) tmo("feed_wr_ready");
    end
    @(negedge clk);
    wr_en = 0;
    wr_last = 0;
  endtask

  task automatic wait_launch();
    int t;
    t = 0;
    while (!send_en && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) tmo("send_en_pulse");
    launch_num = send_data_num;
    launch_drop = drop_err;
  endtask

  task automatic reads(input int n, input int maxgap);
    int g;
    cap.delete();
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      read_data_req = 1;
      @(negedge clk);
      cap.push_back(send_data);
      read_data_req = 0;
      g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      repeat (g) @(negedge clk);
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    send_end = 1;
    @(negedge clk);
    send_end = 0;
    chk("wr_ready_after_send_end", wr_ready, 1);
  endtask

  task automatic load_str(input string s);
    txb.delete();
    for (int i = 0; i < s.len(); i++) txb.push_back(s[i]);
  endtask

  task automatic check_t1(input string tag);
    load_str("http://www");
    feed(1, 0);
    wait_launch();
    chk({tag, "_num"}, launch_num, 10);
    reads(3, 1);
    chk({tag, "_w0"}, cap[0], 32'h68747470);
    chk({tag, "_w1"}, cap[1], 32'h3a2f2f77);
    chk({tag, "_w2"}, cap[2], 32'h77770000);
    end_frame();
  endtask

  initial begin
    int len;
    int nw;
    logic [31:0] lastw;

    repeat (3) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_send_en", send_en, 0);
    chk("rst_send_data", send_data, 0);
    chk("rst_num", send_data_num, 0);
    chk("rst_drop_err", drop_err, 0);
    rst_n = 1;
    @(negedge clk);
    chk("wr_ready_first_clk", wr_ready, 1);

    // T1
    check_t1("t1");

    // T2
    txb.delete();
    for (int i = 1; i <= 4; i++) txb.push_back(8'(i));
    feed(1, 0);
    wait_launch();
    chk("t2_num", launch_num, 4);
    reads(2, 0);
    chk("t2_w0", cap[0], 32'h01020304);
    chk("t2_extra_req", cap[1], 32'h0);
    end_frame();

    // T3: overflow
    txb.delete();
    for (int i = 0; i < MAXB + 3; i++) txb.push_back(8'($urandom));
    feed(1, 0);
    wait_launch();
    chk("t3_num", launch_num, MAXB);
    chk("t3_drop_err", launch_drop, 1);
    reads(MAXB / 4 + 1, 0);
    lastw = {txb[MAXB-4], txb[MAXB-3], txb[MAXB-2], txb[MAXB-1]};
    chk("t3_last_word", cap[MAXB/4 - 1], lastw);
    chk("t3_saturated", cap[MAXB/4], 32'h0);
    end_frame();

    // T4: writes during SEND ignored, then 1-byte payload
    load_str("xyz");
    feed(1, 0);
    wait_launch();
    @(negedge clk);
    wr_en = 1; wr_data = 8'hff; wr_last = 1;
    repeat (4) @(negedge clk);
    wr_en = 0; wr_last = 0;
    chk("t4_num_held", send_data_num, 3);
    end_frame();
    txb.delete();
    txb.push_back(8'hab);
    feed(1, 0);
    wait_launch();
    chk("t4_num", launch_num, 1);
    chk("t4_drop_cleared", launch_drop, 0);
    reads(1, 0);
    chk("t4_w0", cap[0], 32'hab000000);
    end_frame();

    // T5: reset mid-packet
    load_str("http://www");
    txb = txb[0:5];
    feed(0, 0);
    @(negedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    chk("t5_wr_ready", wr_ready, 0);
    chk("t5_send_en", send_en, 0);
    chk("t5_send_data", send_data, 0);
    chk("t5_num", send_data_num, 0);
    chk("t5_drop_err", drop_err, 0);
    rst_n = 1;
    @(negedge clk);
    check_t1("t5");

    // Randomized payloads
    for (int it = 0; it < 24; it++) begin
      len = (it % 8 == 3) ? $urandom_range(MAXB + 6, MAXB - 6) : $urandom_range(40, 1);
      txb.delete();
      for (int i = 0; i < len; i++) txb.push_back(8'($urandom));
      feed(1, 3);
      wait_launch();
      nw = ((len < MAXB ? len : MAXB) + 3) / 4;
      chk("rnd_num", launch_num, 32'(len < MAXB ? len : MAXB));
      reads(nw + $urandom_range(2, 0), (len > 100) ? 0 : 2);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      end_frame();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
